// File: rtl/ctrl_tapseq_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_tapseq_pkg
// Shared definitions for the tap-sequencing controller: FSM state encoding,
// the default accumulator/error register address and the bundle of
// single-bit strobes that the controller registers towards the
// register-file driver.
// ---------------------------------------------------------------------------
package ctrl_tapseq_pkg;

  // Controller FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_MAC  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Register-file address reserved for the running accumulator / error term.
  localparam int ACC_REG_DEFAULT = 0;

  // Single-bit outputs, kept together so they share one register stage.
  typedef struct packed {
    logic en_init;
    logic en_load;
    logic new_smp;
    logic out_smp;
    logic busy;
    logic done;
  } strobes_t;

endpackage

// File: rtl/ctrl_tapseq_if.sv
// ---------------------------------------------------------------------------
// ctrl_tapseq_if
// Request / register-file bus of the tap-sequencing controller.
//   smp_req, out_req, phase : requests towards the controller
//   en_init, en_load, new_smp, out_smp, result_reg, error_reg, coef_addr :
//                             strobes and addresses to the register-file driver
//   busy, done, overrun     : controller status
// Modports:
//   slave  - the controller (accepts requests, drives strobes and status)
//   master - the requester / register-file side
// ---------------------------------------------------------------------------
interface ctrl_tapseq_if #(
  parameter int WIDTH = 3,
  parameter int PW    = 2
);

  logic                  smp_req;
  logic                  out_req;
  logic [PW-1:0]         phase;

  logic                  en_init;
  logic                  en_load;
  logic                  new_smp;
  logic                  out_smp;
  logic [WIDTH-1:0]      result_reg;
  logic [WIDTH-1:0]      error_reg;
  logic [PW+WIDTH-1:0]   coef_addr;

  logic                  busy;
  logic                  done;
  logic                  overrun;

  modport slave (
    input  smp_req, out_req, phase,
    output en_init, en_load, new_smp, out_smp,
    output result_reg, error_reg, coef_addr,
    output busy, done, overrun
  );

  modport master (
    output smp_req, out_req, phase,
    input  en_init, en_load, new_smp, out_smp,
    input  result_reg, error_reg, coef_addr,
    input  busy, done, overrun
  );

endinterface

// File: rtl/ctrl_ringptr.sv
// ---------------------------------------------------------------------------
// ctrl_ringptr
// Ring-buffer write pointer and MAC tap counter.
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   ptr_inc     : advance the write pointer (modulo 2^WIDTH) this cycle
//   k_inc       : advance the tap counter; when low the counter returns to 0
//   wr_ptr_d    : write pointer value after this edge
//   k_d         : tap counter value after this edge
//   tap_addr_d  : (wr_ptr_d - 1 - k_d) mod 2^WIDTH, the ring slot read for
//                 tap k_d (newest sample is at wr_ptr - 1)
//   k_last      : current tap counter is at the final tap
// The "_d" outputs let the controller register its addresses so that they
// line up with the cycle in which the pointer/counter hold those values.
// ---------------------------------------------------------------------------
module ctrl_ringptr #(
  parameter int WIDTH = 3,
  parameter int NTAPS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ptr_inc,
  input  logic             k_inc,
  output logic [WIDTH-1:0] wr_ptr_d,
  output logic [WIDTH-1:0] k_d,
  output logic [WIDTH-1:0] tap_addr_d,
  output logic             k_last
);

  localparam logic [WIDTH-1:0] K_LAST = WIDTH'(NTAPS - 1);

  logic [WIDTH-1:0] wr_ptr_q;
  logic [WIDTH-1:0] k_q;

  always_comb begin
    wr_ptr_d   = ptr_inc ? wr_ptr_q + WIDTH'(1) : wr_ptr_q;
    k_d        = k_inc ? k_q + WIDTH'(1) : '0;
    // Natural WIDTH-bit wrap gives the modulo-2^WIDTH ring arithmetic.
    tap_addr_d = wr_ptr_d - WIDTH'(1) - k_d;
  end

  assign k_last = (k_q == K_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      k_q      <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      k_q      <= k_d;
    end
  end

endmodule

// File: rtl/ctrl_tapseq.sv
// ---------------------------------------------------------------------------
// ctrl_tapseq
// Tap-sequencing controller for a ring-buffer FIR / polyphase filter.
// A sample request writes the next ring slot (INIT, one cycle); an output
// request walks NTAPS taps newest-first (MAC), driving the coefficient ROM
// address {phase, k}; every job ends with a one-cycle DONE.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : ctrl_tapseq_if.slave - requests in, strobes/addresses/status out
// Each request type has a one-deep pending flag; a request arriving while its
// flag is already set is dropped and sets the sticky overrun flag.
// All outputs are registered from the next-state values, so they are valid
// in the same cycle the FSM is in the corresponding state.
// ---------------------------------------------------------------------------
module ctrl_tapseq
  import ctrl_tapseq_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int NTAPS   = 8,
  parameter int PW      = 2,
  parameter int ACC_REG = ACC_REG_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  ctrl_tapseq_if.slave bus
);

  localparam logic [WIDTH-1:0] ACC_ADDR = WIDTH'(ACC_REG);

  // FSM and request bookkeeping
  state_e              state_q,      state_d;
  logic                smp_pend_q,   smp_pend_d;
  logic                out_pend_q,   out_pend_d;
  logic                overrun_q,    overrun_d;
  logic [PW-1:0]       phase_pend_q, phase_pend_d;
  logic [PW-1:0]       phase_q,      phase_d;

  // Registered outputs
  strobes_t            strb_q,       strb_d;
  logic [WIDTH-1:0]    result_reg_q, result_reg_d;
  logic [WIDTH-1:0]    error_reg_q,  error_reg_d;
  logic [PW+WIDTH-1:0] coef_addr_q,  coef_addr_d;

  // Pointer / counter interface
  logic                ptr_inc;
  logic                k_inc;
  logic                k_last;
  logic [WIDTH-1:0]    wr_ptr_d;
  logic [WIDTH-1:0]    k_d;
  logic [WIDTH-1:0]    tap_addr_d;

  logic                smp_svc;
  logic                out_svc;

  ctrl_ringptr #(
    .WIDTH (WIDTH),
    .NTAPS (NTAPS)
  ) u_ringptr (
    .clk        (clk),
    .rst        (rst),
    .ptr_inc    (ptr_inc),
    .k_inc      (k_inc),
    .wr_ptr_d   (wr_ptr_d),
    .k_d        (k_d),
    .tap_addr_d (tap_addr_d),
    .k_last     (k_last)
  );

  // -------------------------------------------------------------------------
  // Next-state and request logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    smp_svc = 1'b0;
    out_svc = 1'b0;
    ptr_inc = 1'b0;
    k_inc   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Sample writes take priority so the ring holds the newest sample
        // before any output computation reads it.
        if (smp_pend_q || bus.smp_req) begin
          state_d = ST_INIT;
          smp_svc = 1'b1;
        end else if (out_pend_q || bus.out_req) begin
          state_d = ST_MAC;
          out_svc = 1'b1;
        end
      end
      ST_INIT: begin
        ptr_inc = 1'b1;
        if (out_pend_q || bus.out_req) begin
          state_d = ST_MAC;
          out_svc = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_MAC: begin
        if (k_last) begin
          state_d = ST_DONE;
        end else begin
          k_inc = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    smp_pend_d = (smp_pend_q | bus.smp_req) & ~smp_svc;
    out_pend_d = (out_pend_q | bus.out_req) & ~out_svc;
    overrun_d  = overrun_q
               | (bus.smp_req & smp_pend_q)
               | (bus.out_req & out_pend_q);

    // Phase is latched when the request is accepted, but only transferred to
    // the working copy on MAC entry, so a request queued during a MAC cannot
    // disturb the coefficient addresses of the computation in progress.
    phase_pend_d = (bus.out_req && !out_pend_q) ? bus.phase : phase_pend_q;
    if (out_svc) begin
      phase_d = out_pend_q ? phase_pend_q : bus.phase;
    end else begin
      phase_d = phase_q;
    end
  end

  // -------------------------------------------------------------------------
  // Output decode from the next state
  // -------------------------------------------------------------------------
  always_comb begin
    strb_d       = '0;
    result_reg_d = '0;
    error_reg_d  = '0;
    coef_addr_d  = '0;

    strb_d.busy  = (state_d != ST_IDLE);

    case (state_d)
      ST_INIT: begin
        strb_d.en_init = 1'b1;
        strb_d.new_smp = 1'b1;
        result_reg_d   = wr_ptr_d;
        error_reg_d    = ACC_ADDR;
      end
      ST_MAC: begin
        strb_d.en_load = 1'b1;
        strb_d.out_smp = (k_d == WIDTH'(NTAPS - 1));
        result_reg_d   = tap_addr_d;
        error_reg_d    = ACC_ADDR;
        coef_addr_d    = {phase_d, k_d};
      end
      ST_DONE: begin
        strb_d.done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      smp_pend_q   <= 1'b0;
      out_pend_q   <= 1'b0;
      overrun_q    <= 1'b0;
      phase_pend_q <= '0;
      phase_q      <= '0;
      strb_q       <= '0;
      result_reg_q <= '0;
      error_reg_q  <= '0;
      coef_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      smp_pend_q   <= smp_pend_d;
      out_pend_q   <= out_pend_d;
      overrun_q    <= overrun_d;
      phase_pend_q <= phase_pend_d;
      phase_q      <= phase_d;
      strb_q       <= strb_d;
      result_reg_q <= result_reg_d;
      error_reg_q  <= error_reg_d;
      coef_addr_q  <= coef_addr_d;
    end
  end

  assign bus.en_init    = strb_q.en_init;
  assign bus.en_load    = strb_q.en_load;
  assign bus.new_smp    = strb_q.new_smp;
  assign bus.out_smp    = strb_q.out_smp;
  assign bus.busy       = strb_q.busy;
  assign bus.done       = strb_q.done;
  assign bus.result_reg = result_reg_q;
  assign bus.error_reg  = error_reg_q;
  assign bus.coef_addr  = coef_addr_q;
  assign bus.overrun    = overrun_q;

endmodule
